ca_run_ctrl: RTL
================

Name: ca_run_ctrl

Overview:
- Command-driven sequencer for the 512-cell rule-90 cellular-automaton engine (ports load/data/q).
- Accepts a seed and a generation count, loads the engine, and counts free-running generations.
- Snapshots the engine state at exactly the requested generation and presents it on a valid/ready result port.
- Sits between a host/command source and the engine; the engine itself stays external.

Parameters:
WIDTH, 512, cell count; must match the engine's data/q width
GEN_W, 16, width of the generation count (max 2^GEN_W-1 generations)

Ports:
clk  input  1  clock, rising edge
areset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when high with cmd_valid
cmd_seed  input  WIDTH  initial cell state
cmd_gens  input  GEN_W  generations to run
abort  input  1  cancel the run in progress
ca_load  output  1  engine load strobe (registered)
ca_data  output  WIDTH  engine load data (registered copy of the seed)
ca_q  input  WIDTH  engine state
res_valid  output  1  result available
res_ready  input  1  result consumed when high with res_valid
res_data  output  WIDTH  captured engine state
res_gens  output  GEN_W  generations actually run
res_early  output  1  run stopped early (zero-stop feature only; else 0)
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE. ca_load=0, ca_data=0, res_valid=0, res_data=0, res_gens=0, res_early=0, counter=0.
- cmd_ready = (state==IDLE). It is combinational from the state register only.
- IDLE: on cmd_valid&&cmd_ready:
  - latch seed into ca_data and cmd_gens into gens_r;
  - set ca_load=1;
  - go to LOAD.
- LOAD (exactly 1 cycle, ca_load=1; the engine loads at the closing edge): clear ca_load, clear cnt, go to RUN.
- RUN: in the cycle with cnt==k, ca_q holds generation k. The engine free-runs, one generation per edge.
  - If cnt==gens_r: capture res_data<=ca_q, res_gens<=cnt, res_valid<=1, go to DONE.
  - Otherwise cnt<=cnt+1.
- DONE: hold res_* stable while res_valid && !res_ready. On res_ready: res_valid<=0, go to IDLE.
  - A new command is accepted only in the cycle after that, so there is no command/result overlap.
- Latency: command accepted at edge E0 -> res_valid high after edge E0+gens+2.
  - gens=0 returns the seed, with res_valid after E0+2.
- abort (sampled in LOAD or RUN): go to IDLE next edge, ca_load=0, no result produced, cnt cleared.
  - abort is ignored in IDLE and DONE.
  - abort coincident with the capture cycle: abort wins and no result is produced.
- cnt is GEN_W+1 bits wide. No wrap is possible because the compare stops counting at gens_r. gens_r = all-ones is legal.
- Engine state after capture is don't-care (it keeps evolving). The controller never relies on it.
- Reset mid-run: immediate return to reset values. ca_load drops asynchronously.

Optional Feature:
CA_ZERO_STOP_EN
- Defined:
  - In RUN, if ca_q==0 and cnt<gens_r: capture immediately with res_data=0, res_gens=cnt, res_early=1.
  - If ca_q==0 and cnt==gens_r: normal capture with res_early=0.
  - Zero-detect is a registered-free WIDTH-wide NOR on ca_q. It adds no latency.
- Undefined: no zero detect, and res_early is tied 0.
- res_early resets to 0 and clears when the result is consumed.

Decomposition:
- Shared package ca_pkg contains:
  - state enum typedef {IDLE, LOAD, RUN, DONE};
  - CA_WIDTH_DEFAULT=512;
  - GEN_W_DEFAULT=16.
- No sub-module. The CA engine is instantiated alongside by the integrating top, not inside this block.

Test Plan:
- Seed {1,510'b0,1}, gens=0, res_ready=1 -> res_data=seed, res_gens=0, res_valid after E0+2, ca_load high exactly 1 cycle.
- Same seed, gens=1 -> res_data has bits 510 and 1 set (0x4000...0002), res_gens=1. Gens=3 result matches a bench rule-90 model (zero boundaries).
- gens=5 with res_ready held 0 for 10 cycles -> res_data/res_gens stable, cmd_ready=0 throughout, cmd_valid ignored. After res_ready, a second command is accepted on the next cycle.
- gens=100, abort pulsed in RUN at cnt=40 -> IDLE next edge, res_valid never rises, next command runs correctly.
- areset_n low during RUN at cnt=7 -> all outputs at reset values immediately. After release, gens=2 command behaves normally.
- Seed all-zero, gens=5:
  - with CA_ZERO_STOP_EN -> res_gens=0, res_early=1, res_valid after E0+2;
  - without it -> res_gens=5, res_early=0, res_data=0.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared types and defaults for the rule-90 cellular-automaton run controller.
package ca_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      DONE
   } state_t;

   localparam int CA_WIDTH_DEFAULT = 512;
   localparam int GEN_W_DEFAULT    = 16;

endpackage

// File: rtl/ca_run_ctrl.sv
// Command sequencer for an external rule-90 engine: loads a seed, counts generations, snapshots the state.
// Optional early stop on an all-zero engine state is enabled by defining CA_ZERO_STOP_EN.
module ca_run_ctrl
   import ca_pkg::*;
#(
   parameter int WIDTH = CA_WIDTH_DEFAULT,
   parameter int GEN_W = GEN_W_DEFAULT
) (
   input  logic             clk,
   input  logic             areset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_seed,
   input  logic [GEN_W-1:0] cmd_gens,
   input  logic             abort,
   output logic             ca_load,
   output logic [WIDTH-1:0] ca_data,
   input  logic [WIDTH-1:0] ca_q,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [GEN_W-1:0] res_gens,
   output logic             res_early,
   output logic             busy
);

   state_t           state;
   state_t           state_next;
   logic [GEN_W-1:0] gens_r;
   logic [GEN_W:0]   cnt;
   logic             at_target;
   logic             zero_stop;
   logic             capture;

   // cnt never passes gens_r, so "not at target" is the same as cnt < gens_r
   assign at_target = (cnt == {1'b0, gens_r});

`ifdef CA_ZERO_STOP_EN
   assign zero_stop = ~(|ca_q) & ~at_target;
`else
   assign zero_stop = 1'b0;
`endif

   assign capture = (state == RUN) && !abort && (at_target || zero_stop);

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      cmd_ready  = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            state_next = abort ? IDLE : RUN;
         end
         RUN: begin
            if (abort) begin
               state_next = IDLE;
            end else if (at_target || zero_stop) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The engine loads at the edge closing LOAD, so cnt==0 lines up with ca_q holding the seed
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         ca_load   <= 1'b0;
         ca_data   <= '0;
         gens_r    <= '0;
         cnt       <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_gens  <= '0;
         res_early <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  ca_data <= cmd_seed;
                  gens_r  <= cmd_gens;
                  ca_load <= 1'b1;
               end
            end
            LOAD: begin
               ca_load <= 1'b0;
               cnt     <= '0;
            end
            RUN: begin
               if (abort) begin
                  cnt <= '0;
               end else if (capture) begin
                  res_data  <= ca_q;
                  res_gens  <= cnt[GEN_W-1:0];
                  res_early <= zero_stop;
                  res_valid <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  res_early <= 1'b0;
               end
            end
            default: begin
               ca_load <= 1'b0;
            end
         endcase
      end
   end

endmodule
